// File: rtl/alu_pkg.sv
// alu_pkg: opcode and flag types shared by the EXE-stage ALU.
// The saturating opcodes 14/15 only write C/V when ALU_PIPE_SAT_EN is defined.
package alu_pkg;

    localparam int OPC_W  = 4;
    localparam int TAG_W  = 5;
    localparam int FLAG_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_NOT  = 4'd6,
        OP_ADC  = 4'd7,
        OP_SBC  = 4'd8,
        OP_SHL  = 4'd9,
        OP_SHR  = 4'd10,
        OP_ASR  = 4'd11,
        OP_CMP  = 4'd12,
        OP_MOV  = 4'd13,
        OP_SADD = 4'd14,
        OP_SSUB = 4'd15
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // Ops that run the adder as a + ~b + cin.
    function automatic logic is_sub(input alu_op_t op);
        return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CMP) || (op == OP_SSUB);
    endfunction

    // Ops whose C and V come from the adder rather than the flag register.
    function automatic logic writes_cv(input alu_op_t op);
        case (op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_CMP: return 1'b1;
`ifdef ALU_PIPE_SAT_EN
            OP_SADD, OP_SSUB:                       return 1'b1;
`endif
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU datapath producing result and NZCV.
// Optional signed saturating add/sub on opcodes 14/15 under ALU_PIPE_SAT_EN.
module alu_core import alu_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  flags_t           flags_in,
    output logic [WIDTH-1:0] result,
    output flags_t           flags
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic [SHW-1:0]   amt;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;
    logic signed [WIDTH:0] asr_src;
    logic [WIDTH:0]   asr_ext;
    logic [WIDTH-1:0] nz_val;
    logic             c_new;
    logic             v_new;
    logic             upd;

    // Clamp an overflowed signed sum to the extreme of the operands' sign.
    function automatic logic signed [WIDTH-1:0] saturate(input logic signed [WIDTH-1:0] raw,
                                                         input logic overflow,
                                                         input logic a_neg);
        logic signed [WIDTH-1:0] smax;
        logic signed [WIDTH-1:0] smin;
        smax = {1'b0, {(WIDTH-1){1'b1}}};
        smin = {1'b1, {(WIDTH-1){1'b0}}};
        if (!overflow)
            return raw;
        return a_neg ? smin : smax;
    endfunction

    // Shared adder, shifters with a guard bit catching the last bit shifted out.
    always_comb begin
        b_eff = is_sub(op) ? ~b : b;
        case (op)
            OP_ADC, OP_SBC:           cin = flags_in.c;
            OP_SUB, OP_CMP, OP_SSUB:  cin = 1'b1;
            default:                  cin = 1'b0;
        endcase
        sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        ovf     = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]);
        amt     = b[SHW-1:0];
        shl_ext = {1'b0, a} << amt;
        shr_ext = {a, 1'b0} >> amt;
        asr_src = {a, 1'b0};
        asr_ext = asr_src >>> amt;
    end

    // Result select and flag generation; NOP/reserved pass the flag register through.
    always_comb begin
        result = '0;
        c_new  = flags_in.c;
        v_new  = flags_in.v;
        upd    = 1'b1;
        case (op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: result = sum[MSB:0];
            OP_CMP:  result = a;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            OP_MOV:  result = b;
            OP_SHL: begin
                result = shl_ext[MSB:0];
                if (amt != '0) c_new = shl_ext[WIDTH];
            end
            OP_SHR: begin
                result = shr_ext[WIDTH:1];
                if (amt != '0) c_new = shr_ext[0];
            end
            OP_ASR: begin
                result = asr_ext[WIDTH:1];
                if (amt != '0) c_new = asr_ext[0];
            end
`ifdef ALU_PIPE_SAT_EN
            OP_SADD, OP_SSUB: result = saturate(sum[MSB:0], ovf, a[MSB]);
`endif
            default: upd = 1'b0;
        endcase
        if (writes_cv(op)) begin
            c_new = sum[WIDTH];
            v_new = ovf;
        end
        nz_val = (op == OP_CMP) ? sum[MSB:0] : result;
        flags  = flags_in;
        if (upd) begin
            flags.n = nz_val[MSB];
            flags.z = (nz_val == '0);
            flags.c = c_new;
            flags.v = v_new;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked EXE-stage ALU, 1-cycle latency, architectural NZCV register.
// Build option ALU_PIPE_SAT_EN enables saturating SADD/SSUB (see alu_core).
module alu_pipe import alu_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  alu_op_t           in_op,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic [FLAG_W-1:0] out_flags,
    output logic [FLAG_W-1:0] flags_q
);

    logic              vld_p1;
    logic [WIDTH-1:0]  result_p1;
    logic [TAG_W-1:0]  tag_p1;
    flags_t            flags_p1;
    logic              accept;
    logic [WIDTH-1:0]  core_result;
    flags_t            core_flags;

    assign in_ready = ~vld_p1 | out_ready;
    assign accept   = in_valid & in_ready;

    alu_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_core (
        .op       (in_op),
        .a        (in_a),
        .b        (in_b),
        .flags_in (flags_t'(flags_q)),
        .result   (core_result),
        .flags    (core_flags)
    );

    // p0 -> p1: load output stage and flag register on accept, drop valid on drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            result_p1 <= '0;
            tag_p1    <= '0;
            flags_p1  <= '0;
            flags_q   <= '0;
        end else if (accept) begin
            vld_p1    <= 1'b1;
            result_p1 <= core_result;
            tag_p1    <= in_tag;
            flags_p1  <= core_flags;
            flags_q   <= core_flags;
        end else if (out_ready) begin
            vld_p1    <= 1'b0;
        end
    end

    assign out_valid  = vld_p1;
    assign out_result = result_p1;
    assign out_tag    = tag_p1;
    assign out_flags  = flags_p1;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe (WIDTH=32) against a
// behavioural model; honours ALU_PIPE_SAT_EN for opcodes 14/15.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
        logic [4:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    alu_op_t     in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic [3:0]  out_flags;
    logic [3:0]  flags_q;

    int   n_checks = 0;
    int   n_errs   = 0;
    exp_t exp_q[$];
    logic [3:0] m_fq;

    alu_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_flags  (out_flags),
        .flags_q    (flags_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic signed_out_of_range(input longint s);
        return (s > SMAX) || (s < SMIN);
    endfunction

    // Behavioural ALU: returns {result, N Z C V} from plain integer arithmetic.
    function automatic logic [35:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [3:0] fq);
        longint      sa, sb, ls;
        logic [63:0] ua, ub, u;
        logic [31:0] res, nzv;
        logic        c, v, bor;
        int          amt;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        c   = fq[1];
        v   = fq[0];
        amt = int'(b[4:0]);
        res = 32'd0;
        case (op)
            4'd1: begin u = ua + ub; res = u[31:0]; c = u[32]; v = signed_out_of_range(sa + sb); end
            4'd2, 4'd12: begin
                res = a - b; c = (a >= b); v = signed_out_of_range(sa - sb);
            end
            4'd7: begin
                u = ua + ub + {63'd0, fq[1]}; res = u[31:0]; c = u[32];
                v = signed_out_of_range(sa + sb + longint'(fq[1]));
            end
            4'd8: begin
                bor = ~fq[1];
                res = a - b - {31'd0, bor}; c = (ua >= ub + {63'd0, bor});
                v = signed_out_of_range(sa - sb - longint'(bor));
            end
            4'd3:  res = a & b;
            4'd4:  res = a | b;
            4'd5:  res = a ^ b;
            4'd6:  res = ~a;
            4'd13: res = b;
            4'd9:  begin res = a << amt; if (amt != 0) c = a[32 - amt]; end
            4'd10: begin res = a >> amt; if (amt != 0) c = a[amt - 1]; end
            4'd11: begin res = $signed(a) >>> amt; if (amt != 0) c = a[amt - 1]; end
`ifdef ALU_PIPE_SAT_EN
            4'd14, 4'd15: begin
                if (op == 4'd14) begin ls = sa + sb; u = ua + ub; c = u[32]; end
                else begin ls = sa - sb; c = (a >= b); end
                if (ls > SMAX)      begin res = 32'h7FFFFFFF; v = 1'b1; end
                else if (ls < SMIN) begin res = 32'h80000000; v = 1'b1; end
                else                begin res = ls[31:0];     v = 1'b0; end
            end
`endif
            default: return {32'd0, fq};
        endcase
        nzv = (op == 4'd12) ? (a - b) : res;
        if (op == 4'd12) res = a;
        return {res, nzv[31], (nzv == 32'd0), c, v};
    endfunction

    // One clock of stimulus; the model tracks the single-entry output stage as a queue.
    task automatic cycle(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag, input logic ordy);
        logic acc;
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_op     = alu_op_t'(op);
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        out_ready = ordy;
        #1;
        check("in_ready", in_ready, (exp_q.size() == 0) || ordy);
        acc = v && ((exp_q.size() == 0) || ordy);
        @(posedge clk);
        if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
        if (acc) begin
            {e.res, e.flags} = ref_alu(op, a, b, m_fq);
            e.tag = tag;
            exp_q.push_back(e);
            m_fq = e.flags;
        end
        #1;
        check("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("out_result", out_result, exp_q[0].res);
            check("out_tag", out_tag, exp_q[0].tag);
            check("out_flags", out_flags, exp_q[0].flags);
        end
        check("flags_q", flags_q, m_fq);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] edges [6];
        edges = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFF0};
        if ($urandom_range(3) == 0) return edges[$urandom_range(5)];
        return $urandom;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = OP_NOP; in_a = '0; in_b = '0; in_tag = '0;
        out_ready = 1'b1; m_fq = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_flags", out_flags, 0);
        check("rst_flags_q", flags_q, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Signed overflow on ADD, visible exactly one cycle after accept.
        cycle(1, 4'd1, 32'h7FFFFFFF, 32'h1, 5'd1, 1);
        check("add_ovf_res", out_result, 32'h80000000);
        check("add_ovf_flags", out_flags, 4'b1001);

        // Carry out feeding a back-to-back ADC.
        cycle(1, 4'd1, 32'hFFFFFFFF, 32'h1, 5'd2, 1);
        check("add_carry_flags", out_flags, 4'b0110);
        cycle(1, 4'd7, 32'h0, 32'h0, 5'd3, 1);
        check("adc_chain_res", out_result, 32'h1);

        // SUB borrow and CMP equality.
        cycle(1, 4'd2, 32'd5, 32'd7, 5'd4, 1);
        check("sub_res", out_result, 32'hFFFFFFFE);
        check("sub_flags", out_flags, 4'b1000);
        cycle(1, 4'd12, 32'd7, 32'd7, 5'd5, 1);
        check("cmp_res", out_result, 32'd7);
        check("cmp_flags", out_flags, 4'b0110);
        check("cmp_flags_q", flags_q, 4'b0110);

        // Back-pressure: op held upstream for 3 stalled cycles, then drained in order.
        cycle(1, 4'd1, 32'd1, 32'd2, 5'd10, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 4'd5, 32'd5, 32'd3, 5'd11, 0);
            check("stall_tag", out_tag, 5'd10);
            check("stall_res", out_result, 32'd3);
        end
        cycle(1, 4'd5, 32'd5, 32'd3, 5'd11, 1);
        check("drain_tag11", out_tag, 5'd11);
        cycle(1, 4'd4, 32'd8, 32'd1, 5'd12, 1);
        check("drain_tag12", out_tag, 5'd12);
        cycle(0, 4'd0, 32'd0, 32'd0, 5'd0, 1);
        check("drain_empty", out_valid, 0);

        // Saturating add (or reserved NOP without the feature).
        cycle(1, 4'd2, 32'd5, 32'd7, 5'd13, 1);
        cycle(1, 4'd14, 32'h7FFFFFF0, 32'h20, 5'd14, 1);
`ifdef ALU_PIPE_SAT_EN
        check("sadd_res", out_result, 32'h7FFFFFFF);
        check("sadd_flags", out_flags, 4'b0001);
`else
        check("sadd_rsv_res", out_result, 32'h0);
        check("sadd_rsv_flags", out_flags, 4'b1000);
`endif

        // Asynchronous reset in the middle of a stall.
        cycle(1, 4'd2, 32'd5, 32'd7, 5'd20, 1);
        cycle(1, 4'd1, 32'd1, 32'd1, 5'd21, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_flags_q", flags_q, 0);
        check("async_rst_result", out_result, 0);
        exp_q.delete();
        m_fq = 4'h0;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(9) < 8), 4'($urandom_range(15)), pick_operand(), pick_operand(),
                  5'($urandom_range(31)), ($urandom_range(9) < 7));
        end
        for (int i = 0; i < 3; i++) cycle(0, 4'd0, 32'd0, 32'd0, 5'd0, 1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the single-cycle execute ALU; sits in the EXE stage between the operand-fetch/bypass logic and writeback.
- Accepts one operation per cycle on a valid/ready interface and returns a registered result with 1-cycle latency.
- Maintains an architectural NZCV flag register, so carry-chained ops (ADC/SBC) work.
- Stalls cleanly under writeback back-pressure.

Parameters:
- WIDTH, 32, operand/result width in bits; legal values 8..64.
- SHW, $clog2(WIDTH), number of shift-amount bits taken from operand2[SHW-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation present on the in_* ports.
- in_ready  out  1  block can accept an operation this cycle.
- in_op  in  4  opcode (alu_pkg::alu_op_t).
- in_a  in  WIDTH  operand1.
- in_b  in  WIDTH  operand2.
- in_tag  in  5  destination tag, passed through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_result  out  WIDTH  registered result.
- out_tag  out  5  tag of the result.
- out_flags  out  4  {N,Z,C,V} produced by this op.
- flags_q  out  4  architectural flag register.

Behaviour:
- Reset (async, any cycle, including mid-stall):
  - out_valid=0, out_result=0, out_tag=0, out_flags=0, flags_q=0.
  - In-flight op discarded.
  - in_ready=1 in the first cycle after deassertion.
- Handshake:
  - in_ready = ~out_valid | out_ready (combinational; no dependence on in_valid).
  - Accept when in_valid & in_ready.
  - Output register holds stable while out_valid & ~out_ready.
  - Simultaneous accept and drain loads the new op; no bubble, full 1 op/cycle throughput.
  - No accept and drain: out_valid falls to 0 next cycle.
- Latency: exactly 1 cycle from accept to out_valid.
- Opcodes:
  - 0 NOP
  - 1 ADD
  - 2 SUB (a-b)
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 NOT (~a)
  - 7 ADC (a+b+C)
  - 8 SBC (a-b-~C, ARM style)
  - 9 SHL
  - 10 SHR (logical)
  - 11 ASR
  - 12 CMP (a-b)
  - 13 MOV (b)
  - 14, 15 reserved
- Arithmetic: computed at WIDTH+1 bits.
  - C = carry out for add-type ops.
  - C = NOT borrow for sub-type ops (a>=b unsigned gives C=1).
  - V = signed overflow from operand and result sign bits of the current op, never from a previous result.
- Flags per op:
  - N = result[WIDTH-1], Z = (result==0) for all non-NOP ops.
  - Logic, shift and MOV ops: C and V are taken from flags_q unchanged.
  - Shift amount = in_b[SHW-1:0]; an amount of 0 leaves C unchanged.
  - Otherwise, for shifts, C = last bit shifted out.
- CMP: out_result = in_a (no writeback change implied); flags updated as for SUB.
- NOP and reserved opcodes:
  - Accepted and produce out_valid with out_result=0 and out_flags=flags_q.
  - flags_q is not modified.
- flags_q:
  - Updated on accept (same edge that loads the output register) with the new op's flags.
  - ADC/SBC read flags_q as it stands at accept, so back-to-back chained ops see the previous op's carry.

Optional Feature:
- Macro: ALU_PIPE_SAT_EN.
- When defined:
  - Opcodes 14 SADD and 15 SSUB perform signed saturating add/sub, clamping to the max/min signed WIDTH value on overflow.
  - V=1 when clamped; C computed as for ADD/SUB.
- When undefined: 14 and 15 behave as reserved (NOP semantics).

Decomposition:
- Package alu_pkg:
  - alu_op_t enum (4 bits).
  - flags_t packed struct {n,z,c,v}.
  - Opcode localparams.
  - is_sub / writes_cv helper functions.
- One sub-module, alu_core: purely combinational; takes op, a, b and flags_q, and produces result and flags.
- alu_pipe owns the handshake, output register, tag and flags_q.

Test Plan:
- WIDTH=32, ADD 0x7FFFFFFF+1 -> result 0x80000000, flags N=1 Z=0 C=0 V=1; out_valid exactly one cycle after accept.
- ADD 0xFFFFFFFF+1, then ADC 0+0 back-to-back -> first op Z=1 C=1; second op result 0x00000001.
- SUB 5-7 -> 0xFFFFFFFE with N=1 C=0 V=0; CMP 7,7 -> result 7, Z=1 C=1, flags_q updated.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, output stable, no op lost; release -> ops drain in order, tags matching.
- Assert rst asynchronously mid-stall -> out_valid=0 and flags_q=0 immediately, without waiting for a clock edge.
- With ALU_PIPE_SAT_EN, SADD 0x7FFFFFF0+0x20 -> 0x7FFFFFFF, V=1; without the macro -> result 0, flags unchanged.
